sram_port_arbiter: RTL and testbench

- Shares one single-port synchronous SRAM (1-cycle read latency, byte write enables) between the CPU instruction port and the CPU data port.
- Lets a unified instruction/data RAM replace the split inst_ram/data_ram pair in the SoC top.
- Grants at most one access per cycle. The data port has priority, with a bounded-streak fairness rule so that instruction fetch cannot starve.
- Returns read data with a per-port valid flag and holds the last read value on each port.

---
 rtl/sram_port_arbiter.sv | 120 ++++++++++++
 tb/tb_sram_port_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Two-port (instruction/data) front end for one single-port synchronous SRAM with 1-cycle read latency.
// Grants are combinational from requests and FSM state; read data returns one cycle after grant with per-port hold.
module sram_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4  // legal range 1..15
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_gnt,
  output logic        inst_rvalid,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic [3:0]  data_wen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_gnt,
  output logic        data_rvalid,
  output logic [31:0] data_rdata,

  output logic        ram_en,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [0:0] {
    DATA_PRI = 1'b0,
    INST_PRI = 1'b1
  } state_e;

  localparam logic [3:0] MAX_STREAK = 4'(MAX_DATA_STREAK);

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        inst_rd_q, inst_rd_d;
  logic        data_rd_q, data_rd_d;
  logic [31:0] inst_hold_q, data_hold_q;

  // Grant selection: the FSM only decides who wins when both ports ask.
  always_comb begin
    inst_gnt = 1'b0;
    data_gnt = 1'b0;
    if (!rst) begin
      case (state_q)
        DATA_PRI: begin
          if (data_req)      data_gnt = 1'b1;
          else if (inst_req) inst_gnt = 1'b1;
        end
        INST_PRI: begin
          if (inst_req)      inst_gnt = 1'b1;
          else if (data_req) data_gnt = 1'b1;
        end
        default: begin
          inst_gnt = 1'b0;
          data_gnt = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ram_en    = inst_gnt | data_gnt;
    ram_addr  = data_gnt ? data_addr : inst_addr;
    ram_wen   = data_gnt ? data_wen : 4'b0000;
    ram_wdata = data_wdata;
  end

  // Streak counts data wins while an instruction fetch is left waiting.
  always_comb begin
    streak_d = streak_q;
    state_d  = state_q;
    if (inst_gnt || !inst_req) begin
      streak_d = 4'd0;
    end else if (data_gnt && (streak_q != 4'hF)) begin
      streak_d = streak_q + 4'd1;
    end

    case (state_q)
      DATA_PRI: if (streak_d == MAX_STREAK) state_d = INST_PRI;
      INST_PRI: if (inst_gnt || !inst_req) state_d = DATA_PRI;
      default:  state_d = DATA_PRI;
    endcase
  end

  always_comb begin
    inst_rd_d = inst_gnt;
    data_rd_d = data_gnt && (data_wen == 4'b0000);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= DATA_PRI;
      streak_q    <= 4'd0;
      inst_rd_q   <= 1'b0;
      data_rd_q   <= 1'b0;
      inst_hold_q <= 32'd0;
      data_hold_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      inst_rd_q <= inst_rd_d;
      data_rd_q <= data_rd_d;
      if (inst_rd_q) inst_hold_q <= ram_rdata;
      if (data_rd_q) data_hold_q <= ram_rdata;
    end
  end

  // A read granted just before reset must not surface while reset is held.
  always_comb begin
    inst_rvalid = inst_rd_q & ~rst;
    data_rvalid = data_rd_q & ~rst;
    inst_rdata  = inst_rvalid ? ram_rdata : inst_hold_q;
    data_rdata  = data_rvalid ? ram_rdata : data_hold_q;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, directed stimulus, scoreboard-checked read returns.
module tb_sram_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt, inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr, data_wdata;
  logic        data_gnt, data_rvalid;
  logic [31:0] data_rdata;
  logic        ram_en;
  logic [3:0]  ram_wen;
  logic [31:0] ram_addr, ram_wdata;
  logic [31:0] ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [31:0] dat;
    int          cyc;
  } exp_t;

  exp_t inst_q[$];
  exp_t data_q[$];

  logic [31:0] mem [0:255];

  sram_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
    .data_rdata(data_rdata),
    .ram_en(ram_en), .ram_wen(ram_wen), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Single-port SRAM, byte write enables, registered read; contents reload on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA500_0000 | 32'(i);
      mem[4] <= 32'h8C01_0004;
      mem[8] <= 32'h1122_3344;
    end else if (ram_en) begin
      if (ram_wen == 4'b0000) begin
        ram_rdata <= mem[ram_addr[9:2]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (ram_wen[b]) mem[ram_addr[9:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_inst(input logic [31:0] d);
    exp_t e;
    e.dat = d;
    e.cyc = cyc + 1;
    inst_q.push_back(e);
  endtask

  task automatic push_data(input logic [31:0] d);
    exp_t e;
    e.dat = d;
    e.cyc = cyc + 1;
    data_q.push_back(e);
  endtask

  // Monitor: every rvalid must match the oldest expected return, on the expected cycle.
  always @(negedge clk) begin
    exp_t e;
    if (inst_rvalid) begin
      if (inst_q.size() == 0) begin
        chk("inst_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = inst_q.pop_front();
        chk("inst_rdata_return", inst_rdata, e.dat);
        chk("inst_rvalid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
    if (data_rvalid) begin
      if (data_q.size() == 0) begin
        chk("data_rvalid_unexpected", 32'd1, 32'd0);
      end else begin
        e = data_q.pop_front();
        chk("data_rdata_return", data_rdata, e.dat);
        chk("data_rvalid_cycle", 32'(cyc), 32'(e.cyc));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] dseq;
    rst = 1'b1;
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_wen = 4'b0000; data_addr = 32'h30; data_wdata = 32'h0;
    tick();

    // Reset with both ports requesting
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
      chk("rst_data_gnt", {31'd0, data_gnt}, 32'd0);
      chk("rst_ram_en", {31'd0, ram_en}, 32'd0);
      chk("rst_ram_wen", {28'd0, ram_wen}, 32'd0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_data_rdata", data_rdata, 32'd0);
      tick();
    end
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_data_gnt", {31'd0, data_gnt}, 32'd1);
    chk("post_rst_inst_gnt", {31'd0, inst_gnt}, 32'd0);
    chk("post_rst_inst_rdata", inst_rdata, 32'd0);
    chk("post_rst_data_rdata", data_rdata, 32'd0);
    if (data_gnt) push_data(32'hA500_000C);
    tick();
    data_req = 1'b0;
    @(negedge clk);
    chk("post_rst_inst_gnt2", {31'd0, inst_gnt}, 32'd1);
    chk("post_rst_inst_rdata2", inst_rdata, 32'd0);
    if (inst_gnt) push_inst(32'hA500_0010);
    tick();
    inst_req = 1'b0;
    tick();

    // Instruction-only read
    inst_req = 1'b1; inst_addr = 32'h10;
    @(negedge clk);
    chk("inst_only_gnt", {31'd0, inst_gnt}, 32'd1);
    chk("inst_only_ram_addr", ram_addr, 32'h10);
    chk("inst_only_ram_wen", {28'd0, ram_wen}, 32'd0);
    chk("inst_only_ram_en", {31'd0, ram_en}, 32'd1);
    if (inst_gnt) push_inst(32'h8C01_0004);
    tick();
    inst_req = 1'b0; inst_addr = 32'hFFFF_FFF0;
    tick();
    @(negedge clk);
    chk("inst_only_rvalid_low", {31'd0, inst_rvalid}, 32'd0);
    chk("inst_only_hold", inst_rdata, 32'h8C01_0004);
    tick();

    // Data partial write then read back
    data_req = 1'b1; data_wen = 4'b0011; data_addr = 32'h20; data_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("wr_data_gnt", {31'd0, data_gnt}, 32'd1);
    chk("wr_ram_wen", {28'd0, ram_wen}, 32'h3);
    chk("wr_ram_wdata", ram_wdata, 32'hDEAD_BEEF);
    chk("wr_ram_addr", ram_addr, 32'h20);
    tick();
    data_wen = 4'b0000;
    @(negedge clk);
    chk("wr_no_rvalid", {31'd0, data_rvalid}, 32'd0);
    chk("wr_rdata_unchanged", data_rdata, 32'hA500_000C);
    chk("rd_data_gnt", {31'd0, data_gnt}, 32'd1);
    if (data_gnt) push_data(32'h1122_BEEF);
    tick();
    data_req = 1'b0;
    tick();
    @(negedge clk);
    chk("rd_data_hold", data_rdata, 32'h1122_BEEF);
    tick();

    // Contention: instruction reads against data writes, 12 cycles
    dseq = 12'b1101_1110_1111;
    inst_req = 1'b1; inst_addr = 32'h40;
    data_req = 1'b1; data_wen = 4'b1111; data_addr = 32'h100; data_wdata = 32'h0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk($sformatf("fair_data_gnt_%0d", i), {31'd0, data_gnt}, {31'd0, dseq[i]});
      chk($sformatf("fair_inst_gnt_%0d", i), {31'd0, inst_gnt}, {31'd0, ~dseq[i]});
      if (inst_gnt) push_inst(32'hA500_0010);
      tick();
    end
    inst_req = 1'b0; data_req = 1'b0;
    tick();

    // Back-to-back alternating reads
    data_wen = 4'b0000;
    inst_req = 1'b1; inst_addr = 32'h44;
    @(negedge clk);
    chk("b2b_inst_gnt_a", {31'd0, inst_gnt}, 32'd1);
    if (inst_gnt) push_inst(32'hA500_0011);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h48;
    @(negedge clk);
    chk("b2b_data_gnt_b", {31'd0, data_gnt}, 32'd1);
    chk("b2b_data_rdata_stable_b", data_rdata, 32'h1122_BEEF);
    if (data_gnt) push_data(32'hA500_0012);
    tick();
    data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h4C;
    @(negedge clk);
    chk("b2b_inst_gnt_c", {31'd0, inst_gnt}, 32'd1);
    chk("b2b_inst_rdata_stable_c", inst_rdata, 32'hA500_0011);
    if (inst_gnt) push_inst(32'hA500_0013);
    tick();
    inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h50;
    @(negedge clk);
    chk("b2b_data_gnt_d", {31'd0, data_gnt}, 32'd1);
    chk("b2b_data_rdata_stable_d", data_rdata, 32'hA500_0012);
    if (data_gnt) push_data(32'hA500_0014);
    tick();
    data_req = 1'b0;
    tick();

    // Reset lands on the cycle a data read would return
    data_req = 1'b1; data_addr = 32'h54;
    @(negedge clk);
    chk("midrst_data_gnt", {31'd0, data_gnt}, 32'd1);
    tick();
    data_req = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("midrst_rvalid_in_rst", {31'd0, data_rvalid}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_rvalid_after", {31'd0, data_rvalid}, 32'd0);
    chk("midrst_data_rdata", data_rdata, 32'd0);
    chk("midrst_inst_rdata", inst_rdata, 32'd0);
    tick();
    tick();

    chk("inst_queue_drained", 32'(inst_q.size()), 32'd0);
    chk("data_queue_drained", 32'(data_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
